mac_tile_mp: RTL and testbench
==============================

Name: mac_tile_mp

Overview:
- Parametrised, multi-precision weight-stationary MAC tile for the 2D systolic array; successor to the fixed dual-lane 2-bit tile.
- Holds LANES activation lanes of bw bits, one signed weight per lane, and LANES psum lanes.
- Independent mode (mode=0): each lane is its own bw-bit MAC.
- Fused mode (mode=1): all lanes form one unsigned LANES*bw-bit activation against a broadcast weight, producing one wide psum.
- Adds a clock-enable stall, weight clear/reload, exec-gated psum pass-through and a weight_ready status.

Parameters:
- bw, 2, activation bits per lane (unsigned)
- wbw, 4, weight bits (signed two's complement); LANES*bw >= wbw is required
- psum_bw, 9, psum bits per lane
- LANES, 2, number of lanes (>=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  clock enable; 0 = every register holds
- wclr  in  1  weight clear; returns load FSM to LOAD, lane 0
- in_w  in  LANES*bw  activations from west, lane i = [i*bw +: bw]; weight load data = in_w[wbw-1:0]
- out_e  out  LANES*bw  registered activations to east
- in_n  in  LANES*psum_bw  psums from north, lane i = [i*psum_bw +: psum_bw]
- out_s  out  LANES*psum_bw  psums to south
- inst_w  in  3  {mode, exec, load}
- inst_e  out  3  registered instruction to east
- weight_ready  out  1  1 when FSM is in READY

Behaviour:
- Reset: a_q=0, c_q=0, all weights=0, inst_q=0, FSM=LOAD, ptr=0.
  - Outputs after reset: out_e=0, inst_e=0, out_s=0, weight_ready=0.
- en=0: all state holds, including FSM, ptr, weights, a_q, c_q and inst_q.
- Priority when en=1: reset > en > wclr > load.
- Capture rules (en=1, no reset):
  - c_q <= in_n every cycle.
  - a_q <= in_w when inst_w[1] or inst_w[0] is set; otherwise a_q holds.
  - inst_q[2:1] <= inst_w[2:1] every cycle.
- Load FSM, state LOAD with lane pointer ptr:
  - load=1, mode=0: w[ptr] <= in_w[wbw-1:0]. If ptr==LANES-1, go to READY; otherwise ptr++.
  - load=1, mode=1: w[all lanes] <= in_w[wbw-1:0], go to READY, regardless of ptr. This discards any partial independent load.
  - inst_q[0] <= 0 in LOAD, including the capturing cycle, so load consumed by this tile is not forwarded east.
- Load FSM, state READY:
  - inst_q[0] <= inst_w[0].
  - Weights are frozen.
  - weight_ready=1.
- wclr=1 (en=1): FSM -> LOAD, ptr=0, inst_q[0] <= 0.
  - Weights keep their old values until overwritten.
  - A load asserted in the same cycle is ignored.
  - a_q, c_q and inst_q[2:1] update normally.
- Latency:
  - out_s is combinational from a_q, w, c_q and inst_q, i.e. one cycle after in_w/in_n are sampled.
  - out_e and inst_e have 1-cycle latency.
- Arithmetic, exec gating: inst_q[1]=0 -> out_s = c_q (pure pass-through, no product added).
- Arithmetic, independent mode (inst_q[1]=1, inst_q[2]=0), per lane i:
  - p_i = unsigned(a_i) * signed(w_i), exact width bw+wbw+1.
  - p_i is sign-extended to psum_bw.
  - out_s lane i = (c_i + p_i) mod 2^psum_bw; wrap, no saturation.
- Arithmetic, fused mode (inst_q[1]=1, inst_q[2]=1), with P = LANES*psum_bw:
  - in_n is one signed P-bit psum C.
  - A = unsigned concatenation of a_q (lane 0 = LSBs).
  - out_s = (C + sum_i sext(a_i*w_0) << (i*bw)) mod 2^P, which equals C + A*w_0.
- Mode is taken per cycle from inst_q[2]. Switching mode does not reload weights; fused mode uses w_0.
- Reset mid-load: all load progress is lost; FSM=LOAD, ptr=0.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> out_s=0, out_e=0, inst_e=0, weight_ready=0.
- Independent load (LANES=2, bw=2, wbw=4, psum_bw=9):
  - Stimulus: inst_w=3'b001 with in_w=4'b1101 (-3), then with in_w=4'b0011 (3).
  - Required: w0=-3, w1=3; weight_ready=1 from the cycle after the 2nd load; inst_e[0]=0 throughout.
  - A 3rd load cycle -> inst_e[0]=1 one cycle later.
- Independent exec: inst_w=3'b010, a=(lane0=2, lane1=3), c=(5, -4) -> next cycle out_s lane0=9'h1FF (-1), lane1=9'd5.
  - Then inst_w=3'b000 with c=(7, 9) -> out_s=(7, 9), a_q unchanged.
- Fused:
  - Stimulus: wclr=1, then inst_w=3'b101 with in_w=4'b1110 (-2).
  - Required: weight_ready=1 after 1 load.
  - Exec: inst_w=3'b110, in_w=4'b1011 (11), in_n=18'd100 -> out_s=18'd78.
- Stall and priority:
  - en=0 for 3 cycles with changing inputs -> out_s, out_e, inst_e frozen.
  - wclr and load in the same cycle -> weights unchanged, FSM=LOAD ptr=0, inst_e[0]=0.
- Mid-load reset: one mode-0 load, then reset, then two loads of 4'b0001 and 4'b0010 -> w0=1, w1=2, weight_ready=1.
- Partial-load override: one mode-0 load (ptr=1), then a mode-1 load of 4'b0101 -> both weights=5, READY.

Source files
------------

// File: rtl/mac_tile_mp.sv
// Multi-precision weight-stationary MAC tile: LANES independent bw-bit MACs, or one
// fused LANES*bw-bit unsigned activation against the lane-0 weight.
module mac_tile_mp #(
    parameter int bw      = 2,
    parameter int wbw     = 4,
    parameter int psum_bw = 9,
    parameter int LANES   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       wclr,
    input  logic [LANES*bw-1:0]        in_w,
    output logic [LANES*bw-1:0]        out_e,
    input  logic [LANES*psum_bw-1:0]   in_n,
    output logic [LANES*psum_bw-1:0]   out_s,
    input  logic [2:0]                 inst_w,
    output logic [2:0]                 inst_e,
    output logic                       weight_ready
);

    localparam int PROD_W = bw + wbw + 1;
    localparam int P      = LANES * psum_bw;
    localparam int PTR_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    logic [LANES*bw-1:0]      r_a_q;
    logic [P-1:0]             r_c_q;
    logic signed [wbw-1:0]    r_w [LANES];
    logic [2:0]               r_inst_q;
    state_t                   r_state;
    logic [PTR_W-1:0]         r_ptr;

    // inst_q[0] is only forwarded once this tile holds its weights, so loads it consumes stop here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_q    <= '0;
            r_c_q    <= '0;
            r_inst_q <= '0;
            r_state  <= ST_LOAD;
            r_ptr    <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_w[i] <= '0;
            end
        end else if (en) begin
            r_c_q         <= in_n;
            r_inst_q[2:1] <= inst_w[2:1];
            if (inst_w[1] || inst_w[0]) begin
                r_a_q <= in_w;
            end
            if (wclr) begin
                r_state     <= ST_LOAD;
                r_ptr       <= '0;
                r_inst_q[0] <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        r_inst_q[0] <= 1'b0;
                        if (inst_w[0]) begin
                            if (inst_w[2]) begin
                                for (int i = 0; i < LANES; i++) begin
                                    r_w[i] <= in_w[wbw-1:0];
                                end
                                r_state <= ST_READY;
                                r_ptr   <= '0;
                            end else begin
                                r_w[r_ptr] <= in_w[wbw-1:0];
                                if (r_ptr == LAST_LANE) begin
                                    r_state <= ST_READY;
                                    r_ptr   <= '0;
                                end else begin
                                    r_ptr <= r_ptr + PTR_W'(1);
                                end
                            end
                        end
                    end
                    ST_READY: begin
                        r_inst_q[0] <= inst_w[0];
                    end
                    default: begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                    end
                endcase
            end
        end
    end

    logic [P-1:0] w_ind_sum;
    logic [P-1:0] w_fus_acc [LANES+1];

    assign w_fus_acc[0] = r_c_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [PROD_W-1:0] w_a_ext;
            logic signed [PROD_W-1:0] w_wi_ext;
            logic signed [PROD_W-1:0] w_w0_ext;
            logic signed [PROD_W-1:0] w_ind_prod;
            logic signed [PROD_W-1:0] w_fus_prod;
            logic signed [P-1:0]      w_fus_ext;

            // Activations are unsigned: zero-extend; weights are signed: sign-extend.
            assign w_a_ext    = PROD_W'(r_a_q[gi*bw +: bw]);
            assign w_wi_ext   = PROD_W'(r_w[gi]);
            assign w_w0_ext   = PROD_W'(r_w[0]);
            assign w_ind_prod = w_a_ext * w_wi_ext;
            assign w_fus_prod = w_a_ext * w_w0_ext;
            assign w_fus_ext  = P'(w_fus_prod);

            assign w_ind_sum[gi*psum_bw +: psum_bw] =
                r_c_q[gi*psum_bw +: psum_bw] + psum_bw'(w_ind_prod);

            // Shifted partial products sum to C + A*w_0 modulo 2^P.
            assign w_fus_acc[gi+1] = w_fus_acc[gi] + (w_fus_ext << (gi*bw));
        end
    endgenerate

    always_comb begin
        out_s = r_c_q;
        if (r_inst_q[1]) begin
            if (r_inst_q[2]) begin
                out_s = w_fus_acc[LANES];
            end else begin
                out_s = w_ind_sum;
            end
        end
    end

    assign out_e        = r_a_q;
    assign inst_e       = r_inst_q;
    assign weight_ready = (r_state == ST_READY);

endmodule

// File: tb/tb_mac_tile_mp.sv
// Directed-vector bench for mac_tile_mp (LANES=2, bw=2, wbw=4, psum_bw=9).
module tb_mac_tile_mp;

    localparam int BW = 2, WBW = 4, PBW = 9, LN = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic               wclr;
    logic [LN*BW-1:0]   in_w;
    logic [LN*BW-1:0]   out_e;
    logic [LN*PBW-1:0]  in_n;
    logic [LN*PBW-1:0]  out_s;
    logic [2:0]         inst_w;
    logic [2:0]         inst_e;
    logic               weight_ready;

    int n_cmp = 0;
    int n_err = 0;

    mac_tile_mp #(.bw(BW), .wbw(WBW), .psum_bw(PBW), .LANES(LN)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .wclr         (wclr),
        .in_w         (in_w),
        .out_e        (out_e),
        .in_n         (in_n),
        .out_s        (out_s),
        .inst_w       (inst_w),
        .inst_e       (inst_e),
        .weight_ready (weight_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b1; wclr = 1'b0; inst_w = '0; in_w = '0; in_n = '0;

        // Reset with random inputs
        repeat (2) begin
            in_w   = 4'($urandom);
            in_n   = 18'($urandom);
            inst_w = 3'($urandom);
            step();
        end
        chk("rst_out_s", 64'(out_s), 64'd0);
        chk("rst_out_e", 64'(out_e), 64'd0);
        chk("rst_inst_e", 64'(inst_e), 64'd0);
        chk("rst_wready", 64'(weight_ready), 64'd0);

        reset = 1'b0; in_w = '0; in_n = '0; inst_w = '0;
        step();

        // Independent load: w0=-3, w1=3
        inst_w = 3'b001; in_w = 4'b1101;
        step();
        chk("ld1_wready", 64'(weight_ready), 64'd0);
        chk("ld1_inst_e", 64'(inst_e), 64'd0);
        in_w = 4'b0011;
        step();
        chk("ld2_wready", 64'(weight_ready), 64'd1);
        chk("ld2_inst_e", 64'(inst_e), 64'd0);
        in_w = 4'b0110;
        step();
        chk("ld3_inst_e", 64'(inst_e), 64'b001);
        chk("ld3_out_e", 64'(out_e), 64'b0110);

        // Independent exec: a=(2,3), c=(5,-4)
        inst_w = 3'b010; in_w = 4'b1110; in_n = {9'h1FC, 9'd5};
        step();
        chk("ind_out_s", 64'(out_s), 64'({9'd5, 9'h1FF}));
        chk("ind_inst_e", 64'(inst_e), 64'b010);
        chk("ind_out_e", 64'(out_e), 64'b1110);

        // Pass-through: a_q must not capture
        inst_w = 3'b000; in_w = 4'b0001; in_n = {9'd9, 9'd7};
        step();
        chk("pass_out_s", 64'(out_s), 64'({9'd9, 9'd7}));
        chk("pass_out_e", 64'(out_e), 64'b1110);
        chk("pass_inst_e", 64'(inst_e), 64'b000);

        // Fused: clear, broadcast load of -2, then exec A=11
        wclr = 1'b1; inst_w = 3'b000; in_n = '0;
        step();
        chk("wclr_wready", 64'(weight_ready), 64'd0);
        wclr = 1'b0; inst_w = 3'b101; in_w = 4'b1110;
        step();
        chk("fld_wready", 64'(weight_ready), 64'd1);
        chk("fld_inst_e", 64'(inst_e), 64'b100);
        inst_w = 3'b110; in_w = 4'b1011; in_n = 18'd100;
        step();
        chk("fus_out_s", 64'(out_s), 64'd78);
        chk("fus_inst_e", 64'(inst_e), 64'b110);
        in_w = 4'b1111; in_n = 18'd10;
        step();
        chk("fus_neg_out_s", 64'(out_s), 64'h3FFEC);

        // Stall: everything frozen while en=0
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_w   = 4'($urandom);
            in_n   = 18'($urandom);
            inst_w = 3'b001;
            wclr   = (k == 1);
            step();
            chk("stall_out_s", 64'(out_s), 64'h3FFEC);
            chk("stall_out_e", 64'(out_e), 64'hF);
            chk("stall_inst_e", 64'(inst_e), 64'b110);
            chk("stall_wready", 64'(weight_ready), 64'd1);
        end

        // wclr and load together: load ignored, weights stay -2
        en = 1'b1; wclr = 1'b1; inst_w = 3'b001; in_w = 4'b0111; in_n = '0;
        step();
        chk("clrld_inst_e", 64'(inst_e), 64'b000);
        chk("clrld_wready", 64'(weight_ready), 64'd0);
        chk("clrld_out_e", 64'(out_e), 64'b0111);
        chk("clrld_out_s", 64'(out_s), 64'd0);
        wclr = 1'b0; inst_w = 3'b010; in_w = 4'b0101;
        step();
        chk("clrld_w_kept", 64'(out_s), 64'({9'h1FE, 9'h1FE}));
        // Next mode-0 load must land in lane 0
        inst_w = 3'b001; in_w = 4'b0100;
        step();
        chk("ptr0_wready", 64'(weight_ready), 64'd0);
        inst_w = 3'b010; in_w = 4'b0101;
        step();
        chk("ptr0_out_s", 64'(out_s), 64'({9'h1FE, 9'd4}));

        // Mid-load reset (ptr=1 at this point), then reload w0=1, w1=2
        reset = 1'b1; inst_w = 3'b000;
        step();
        reset = 1'b0;
        chk("mrst_wready", 64'(weight_ready), 64'd0);
        inst_w = 3'b001; in_w = 4'b0001;
        step();
        in_w = 4'b0010;
        step();
        chk("mrst_ld_wready", 64'(weight_ready), 64'd1);
        inst_w = 3'b010; in_w = 4'b1011; in_n = {9'd20, 9'd10};
        step();
        chk("mrst_out_s", 64'(out_s), 64'({9'd24, 9'd13}));

        // Partial load overridden by broadcast load of 5
        wclr = 1'b1; inst_w = 3'b000; in_n = '0;
        step();
        wclr = 1'b0; inst_w = 3'b001; in_w = 4'b0111;
        step();
        chk("part_wready", 64'(weight_ready), 64'd0);
        inst_w = 3'b101; in_w = 4'b0101;
        step();
        chk("ovr_wready", 64'(weight_ready), 64'd1);
        inst_w = 3'b010; in_w = 4'b0101;
        step();
        chk("ovr_ind_out_s", 64'(out_s), 64'({9'd5, 9'd5}));
        inst_w = 3'b110; in_w = 4'b0011;
        step();
        chk("ovr_fus_out_s", 64'(out_s), 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
